sign_ext_pipe: RTL and testbench
================================

Name: sign_ext_pipe

Overview:
- Parametrised, registered immediate/data extender for the MIPS datapath, and the successor to the combinational 16-to-32 sign extender.
- Extends an IN_W-bit field to OUT_W bits in one of several modes: zero, sign, byte-sign, and LUI when compiled in.
- Valid/ready handshake on both sides, with a 2-entry skid buffer so a stalled consumer never drops data.
- Sits between decode (immediate field) and the ID/EX stage, or after data memory for load-data extension.

Parameters:
- IN_W, 16, input field width; must be >= 8.
- OUT_W, 32, output width; must be > IN_W.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- Flush  in  1  synchronous discard of all buffered entries.
- In  in  IN_W  field to extend.
- Mode  in  2  00=ZEXT, 01=SEXT, 10=SEXT8, 11=LUI (see Optional Feature).
- InValid  in  1  In/Mode valid.
- InReady  out  1  block can accept this cycle.
- Out  out  OUT_W  extended result.
- OutValid  out  1  Out valid.
- OutReady  in  1  consumer accepts Out.

Behaviour:
- Extension function f(In, Mode):
  - ZEXT: zeros in the upper OUT_W-IN_W bits, then In.
  - SEXT: In[IN_W-1] replicated into the upper OUT_W-IN_W bits, then In.
  - SEXT8: In[7] replicated into bits OUT_W-1..8, then In[7:0]. In[IN_W-1:8] is ignored.
  - LUI: see Optional Feature.
- Handshakes:
  - Input transfer occurs when InValid && InReady.
  - Output transfer occurs when OutValid && OutReady.
- Storage: main register M (drives Out) and skid register S. Each holds an f() result.
- State machine, with transitions evaluated at the clock edge when Reset=1 and Flush=0:
  - EMPTY (OutValid=0, InReady=1): input transfer -> ONE, M<=f. Otherwise stay.
  - ONE (OutValid=1, InReady=1):
    - input and output both transfer -> stay ONE, M<=f.
    - input only -> FULL, S<=f.
    - output only -> EMPTY.
    - neither -> stay.
  - FULL (OutValid=1, InReady=0):
    - output transfer -> ONE, M<=S.
    - Input is never accepted in FULL.
- Ordering is strict FIFO.
- Latency is 1 cycle: data accepted at edge N appears on Out after edge N when the block was EMPTY, or when the block was ONE and OutReady was high.
- Throughput is 1 per cycle while OutReady stays high.
- InReady and OutValid are decoded from state (registered). There is no combinational path from OutReady to InReady.
- Out holds its value while OutValid=1 and OutReady=0, and must not change until the transfer completes.
- Reset (Reset=0 at an edge):
  - State=EMPTY, M=0, S=0.
  - Out=0, OutValid=0.
  - InReady is forced 0 while Reset=0. It reads 1 the cycle after release.
- Flush=1 at an edge:
  - State goes to EMPTY and M, S are cleared to 0.
  - InReady is forced 0 during that cycle, so no input transfer occurs.
  - An output transfer in the same cycle still counts as consumed.
  - Reset has priority over Flush.
- Mid-operation reset or flush discards both entries and emits no partial output.
- Out is 0 whenever OutValid=0 (M is cleared when going to EMPTY).
- Mode and In are sampled only on an input transfer.

Optional Feature:
- Macro: SIGN_EXT_PIPE_LUI_EN.
- Defined: Mode 11 = LUI. The result is In placed in the upper IN_W bits, with zeros in the lower OUT_W-IN_W bits (In<<16 for default widths). This requires OUT_W >= 2*IN_W; a violation is flagged by a generate-time error.
- Undefined: Mode 11 behaves exactly as ZEXT, and no LUI logic is synthesised.

Test Plan:
- Reset=0 for 3 cycles, then release -> Out=0, OutValid=0 throughout reset; InReady=1 on the first cycle after release.
- OutReady=1, stream In=16'h8001 SEXT, 16'h8001 ZEXT, 16'h0080 SEXT8, 16'h007F SEXT8 -> Out=FFFF8001, 00008001, FFFFFF80, 0000007F on consecutive cycles, each 1 cycle after acceptance.
- OutReady=0 and push 2 items (16'hFFFF SEXT, 16'h1234 ZEXT) -> second push accepted and state FULL; third push stalls with InReady=0; Out stable at FFFFFFFF. Raise OutReady -> FFFFFFFF, then 00001234, in order with no loss.
- In FULL, assert Flush=1 with InValid=1 for one cycle -> next cycle OutValid=0, Out=0, InReady=1; flushed input not delivered.
- Mode=11, In=16'h1234 -> Out=12340000 with SIGN_EXT_PIPE_LUI_EN defined, 00001234 without.
- Build with IN_W=8, OUT_W=16: In=8'h9C SEXT -> FF9C; ZEXT -> 009C; Reset=0 asserted mid-stream drops all pending data.

Source files
------------

// File: rtl/sign_ext_pipe.sv
// sign_ext_pipe
//   Registered immediate/data extender with a valid/ready handshake on both
//   sides and a two-entry skid buffer. It widens an IN_W-bit field to OUT_W
//   bits and sits after decode (immediate) or after data memory (load data).
//
//   Modes: 00 ZEXT, 01 SEXT, 10 SEXT8 (sign from bit 7), 11 LUI or ZEXT.
//   Build option SIGN_EXT_PIPE_LUI_EN: when defined, mode 11 places the field
//   in the upper IN_W bits and fills the rest with zeros. When it is not
//   defined, mode 11 behaves as ZEXT and no LUI logic exists.
//
//   Ports
//     clk        rising-edge clock
//     reset      synchronous, active-low reset
//     flush      synchronous discard of both buffered entries
//     in         field to extend (IN_W bits)
//     mode       extension mode, sampled with in on an input transfer
//     in_valid   in/mode valid
//     in_ready   block can accept this cycle
//     out        extended result (OUT_W bits), 0 whenever out_valid=0
//     out_valid  out valid
//     out_ready  consumer accepts out
//
//   state | meaning
//   EMPTY | nothing buffered; out=0, ready for input
//   ONE   | main register holds the head entry; still ready for input
//   FULL  | main + skid registers both hold entries; input blocked
module sign_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [IN_W-1:0]  in,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  if (IN_W < 8) begin : g_bad_in_w
    $error("sign_ext_pipe: IN_W must be at least 8");
  end
  if (OUT_W <= IN_W) begin : g_bad_out_w
    $error("sign_ext_pipe: OUT_W must be greater than IN_W");
  end
`ifdef SIGN_EXT_PIPE_LUI_EN
  if (OUT_W < 2 * IN_W) begin : g_bad_lui_w
    $error("sign_ext_pipe: LUI mode needs OUT_W >= 2*IN_W");
  end
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [OUT_W-1:0] m_q;
  logic [OUT_W-1:0] s_q;
  logic [OUT_W-1:0] ext_val;
  logic             in_xfer;
  logic             out_xfer;

  function automatic logic [OUT_W-1:0] ext_f(input logic [IN_W-1:0] d,
                                              input logic [1:0]      m);
    logic [OUT_W-1:0] r;
    case (m)
      2'b01:   r = {{(OUT_W-IN_W){d[IN_W-1]}}, d};
      2'b10:   r = {{(OUT_W-8){d[7]}}, d[7:0]};
`ifdef SIGN_EXT_PIPE_LUI_EN
      2'b11:   r = {d, {(OUT_W-IN_W){1'b0}}};
`endif
      default: r = {{(OUT_W-IN_W){1'b0}}, d};
    endcase
    return r;
  endfunction

  assign ext_val = ext_f(in, mode);

  // Ready comes from registered state only; reset and flush just mask it so
  // nothing is accepted on an edge that is about to discard the buffer.
  assign in_ready  = reset & ~flush & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out       = m_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state <= EMPTY;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            m_q   <= ext_val;
            state <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            m_q <= ext_val;
          end else if (in_xfer) begin
            s_q   <= ext_val;
            state <= FULL;
          end else if (out_xfer) begin
            // keep out at zero while nothing is valid
            m_q   <= '0;
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            m_q   <= s_q;
            s_q   <= '0;
            state <= ONE;
          end
        end
        default: begin
          m_q   <= '0;
          s_q   <= '0;
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sign_ext_pipe.sv
module tb_sign_ext_pipe;

  localparam logic [1:0] ZEXT  = 2'b00;
  localparam logic [1:0] SEXT  = 2'b01;
  localparam logic [1:0] SEXT8 = 2'b10;
  localparam logic [1:0] LUI   = 2'b11;

  logic        clk;
  int          checks   = 0;
  int          failures = 0;

  // 16 -> 32 instance
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in;
  logic [1:0]  mode;
  logic [31:0] out;

  // 8 -> 16 instance
  logic        b_reset, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in;
  logic [1:0]  b_mode;
  logic [15:0] b_out;

  sign_ext_pipe #(.IN_W(16), .OUT_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in(in), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .out(out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  sign_ext_pipe #(.IN_W(8), .OUT_W(16)) dut_b (
    .clk(clk), .reset(b_reset), .flush(b_flush), .in(b_in), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out(b_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference extension with plain arithmetic on unsigned values.
  function automatic longint unsigned ref_ext(input int in_w, input int out_w,
                                              input longint unsigned v, input logic [1:0] m);
    longint unsigned full_in  = 64'd1 << in_w;
    longint unsigned full_out = 64'd1 << out_w;
    longint unsigned lo;
    case (m)
      SEXT:  return (v >= full_in / 2) ? v + full_out - full_in : v;
      SEXT8: begin
        lo = v % 256;
        return (lo >= 128) ? lo + full_out - 256 : lo;
      end
`ifdef SIGN_EXT_PIPE_LUI_EN
      LUI:   return v * (64'd1 << (out_w - in_w));
`endif
      default: return v;
    endcase
  endfunction

  // Scoreboard for the 16->32 instance: a FIFO of capacity two.
  logic [31:0] q[$];
  logic        exp_rdy;

  always @(negedge clk) begin
    exp_rdy = reset && !flush && (q.size() < 2);
    check("sb_in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    check("sb_out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) check("sb_out", {32'd0, out}, {32'd0, q[0]});
    else              check("sb_out_idle", {32'd0, out}, 64'd0);
    if (!reset || flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (exp_rdy && in_valid) q.push_back(32'(ref_ext(16, 32, {48'd0, in}, mode)));
    end
  end

  typedef struct {
    logic [15:0] in;
    logic [1:0]  mode;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0] = '{16'h8001, SEXT,  32'hFFFF8001};
    tbl[1] = '{16'h8001, ZEXT,  32'h00008001};
    tbl[2] = '{16'h0080, SEXT8, 32'hFFFFFF80};
    tbl[3] = '{16'h007F, SEXT8, 32'h0000007F};
    tbl[4] = '{16'hFF7F, SEXT8, 32'h0000007F};
    tbl[5] = '{16'h7FFF, SEXT,  32'h00007FFF};
`ifdef SIGN_EXT_PIPE_LUI_EN
    tbl[6] = '{16'h1234, LUI,   32'h12340000};
`else
    tbl[6] = '{16'h1234, LUI,   32'h00001234};
`endif

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in = '0; mode = ZEXT;
    b_reset = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_in = '0; b_mode = ZEXT;

    // reset held for three edges
    repeat (3) begin
      tick();
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_out", {32'd0, out}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    end
    reset = 1'b1;
    tick();
    check("rel_in_ready", {63'd0, in_ready}, 64'd1);

    // streaming, one per cycle, one cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in = tbl[i].in; mode = tbl[i].mode; in_valid = 1'b1;
      tick();
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      check("stream_out", {32'd0, out}, {32'd0, tbl[i].exp});
    end
    in_valid = 1'b0;
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_out", {32'd0, out}, 64'd0);

    // stall: fill both entries, third push blocked
    out_ready = 1'b0;
    in = 16'hFFFF; mode = SEXT; in_valid = 1'b1;
    tick();
    check("stall_first", {32'd0, out}, 64'hFFFFFFFF);
    in = 16'h1234; mode = ZEXT;
    tick();
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_out", {32'd0, out}, 64'hFFFFFFFF);
    in = 16'h5555;
    repeat (2) begin
      tick();
      check("full_hold_ready", {63'd0, in_ready}, 64'd0);
      check("full_hold_out", {32'd0, out}, 64'hFFFFFFFF);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("unstall_second", {32'd0, out}, 64'h00001234);
    check("unstall_valid", {63'd0, out_valid}, 64'd1);
    tick();
    check("unstall_empty", {63'd0, out_valid}, 64'd0);

    // flush while full, with a competing push
    out_ready = 1'b0;
    in = 16'hAAAA; mode = SEXT; in_valid = 1'b1;
    tick();
    in = 16'h0BBB; mode = ZEXT;
    tick();
    flush = 1'b1; in = 16'h4321;
    #1;
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_out", {32'd0, out}, 64'd0);
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick();
    check("flush_no_deliver", {63'd0, out_valid}, 64'd0);

    // randomized traffic against the scoreboard
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in        = 16'($urandom);
      mode      = 2'($urandom % 4);
      flush     = ($urandom % 40) == 0;
      reset     = ($urandom % 70) != 0;
      tick();
    end
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    // 8 -> 16 instance
    b_reset = 1'b1;
    tick();
    check("b_rel_ready", {63'd0, b_in_ready}, 64'd1);
    b_in = 8'h9C; b_mode = SEXT; b_in_valid = 1'b1; b_out_ready = 1'b1;
    tick();
    check("b_sext", {48'd0, b_out}, 64'hFF9C);
    b_mode = ZEXT;
    tick();
    check("b_zext", {48'd0, b_out}, 64'h009C);
    b_out_ready = 1'b0; b_in = 8'h12; b_mode = SEXT;
    tick();
    check("b_full_ready", {63'd0, b_in_ready}, 64'd0);
    b_reset = 1'b0; b_in_valid = 1'b0;
    #1;
    check("b_rst_ready", {63'd0, b_in_ready}, 64'd0);
    @(posedge clk);
    #1;
    check("b_rst_valid", {63'd0, b_out_valid}, 64'd0);
    check("b_rst_out", {48'd0, b_out}, 64'd0);
    b_reset = 1'b1; b_out_ready = 1'b1;
    #1;
    check("b_rel2_ready", {63'd0, b_in_ready}, 64'd1);
    tick();
    check("b_dropped", {63'd0, b_out_valid}, 64'd0);
    check("b_dropped_out", {48'd0, b_out}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
